wb_arbiter: RTL and testbench

- Writeback-side producer for the integer register file: drives its single write port (RegWr, write_reg, write_data).
- Merges two completion streams into that port:
  - single-cycle ALU results;
  - multi-cycle load results, buffered in a small FIFO.
- Fixed ALU priority, with a starvation guard so queued loads always retire.
- Writes to x0 are accepted and discarded.

---
 rtl/wb_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered load results into the single register file write port.
// Optional WB_BYPASS_EN: a load arriving at an idle, empty unit skips the FIFO and writes with latency 1.
//
// state  | meaning
// NORMAL | ALU has priority; the FIFO head pops whenever the ALU is idle
// DRAIN  | one-cycle forced pop after the FIFO lost STARVE_MAX cycles in a row
module wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  output logic                     RegWr,
  output logic [4:0]               write_reg,
  output logic [XLEN-1:0]          write_data,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   FULL_CNT    = DEPTH[AW:0];
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);
`ifdef WB_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  typedef enum logic {NORMAL, DRAIN} state_t;

  state_t            state, state_next;
  logic [4:0]        rd_mem   [DEPTH];
  logic [XLEN-1:0]   data_mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [SW-1:0]     starve, starve_next;
  logic              empty, full, push, pop, bypass, sel_valid;
  logic [4:0]        sel_rd;
  logic [XLEN-1:0]   sel_data;

  assign empty     = (q_count == '0);
  assign full      = (q_count == FULL_CNT);
  assign ld_ready  = !full;
  assign alu_ready = (state == NORMAL);

  always_comb begin
    state_next  = state;
    starve_next = starve;
    pop         = 1'b0;
    bypass      = 1'b0;
    sel_valid   = 1'b0;
    sel_rd      = alu_rd;
    sel_data    = alu_data;
    case (state)
      NORMAL: begin
        if (alu_valid) begin
          sel_valid = 1'b1;
          if (empty) begin
            starve_next = '0;
          end else begin
            starve_next = starve + 1'b1;
            // Switch on the edge where the counter reaches STARVE_MAX.
            if (starve == STARVE_LAST) state_next = DRAIN;
          end
        end else if (!empty) begin
          pop         = 1'b1;
          sel_valid   = 1'b1;
          sel_rd      = rd_mem[rd_ptr];
          sel_data    = data_mem[rd_ptr];
          starve_next = '0;
        end else begin
          starve_next = '0;
          if (BYPASS_EN && ld_valid) begin
            bypass    = 1'b1;
            sel_valid = 1'b1;
            sel_rd    = ld_rd;
            sel_data  = ld_data;
          end
        end
      end
      DRAIN: begin
        pop         = !empty;
        sel_valid   = !empty;
        sel_rd      = rd_mem[rd_ptr];
        sel_data    = data_mem[rd_ptr];
        starve_next = '0;
        state_next  = NORMAL;
      end
      default: state_next = NORMAL;
    endcase
    push = ld_valid && !full && !bypass;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= NORMAL;
      starve     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_count    <= '0;
      RegWr      <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      state  <= state_next;
      starve <= starve_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
      // x0 writes complete the handshake but never assert the write enable.
      RegWr <= sel_valid && (sel_rd != 5'd0);
      if (sel_valid) begin
        write_reg  <= sel_rd;
        write_data <= sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= ld_rd;
      data_mem[wr_ptr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, checked against a queue-based reference model.
module tb_wb_arbiter;

  localparam int XLEN       = 32;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, alu_ready;
  logic [4:0]        alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              ld_valid, ld_ready;
  logic [4:0]        ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic              RegWr;
  logic [4:0]        write_reg;
  logic [XLEN-1:0]   write_data;
  logic [$clog2(DEPTH):0] q_count;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .RegWr(RegWr), .write_reg(write_reg), .write_data(write_data), .q_count(q_count)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } res_t;

  // Reference model: pending loads, starvation streak, forced-drain flag, expected port values.
  res_t            ld_q[$];
  int              starve;
  bit              drain;
  bit              exp_wr;
  logic [4:0]      exp_reg;
  logic [XLEN-1:0] exp_data;
  bit              alu_acc, ld_acc;
  int              n_tests = 0;
  int              n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ld_q.delete();
    starve   = 0;
    drain    = 0;
    exp_wr   = 0;
    exp_reg  = '0;
    exp_data = '0;
    alu_acc  = 0;
    ld_acc   = 0;
  endtask

  // Called at a falling edge once this cycle's inputs are applied.
  task automatic step();
    bit   a_rdy, l_rdy, sel, byp, popped;
    int   sz;
    res_t s;
    check_val("RegWr", {31'd0, RegWr}, {31'd0, exp_wr});
    check_val("write_reg", {27'd0, write_reg}, {27'd0, exp_reg});
    check_val("write_data", write_data, exp_data);
    sz    = ld_q.size();
    a_rdy = !drain;
    l_rdy = (sz != DEPTH);
    check_val("alu_ready", {31'd0, alu_ready}, {31'd0, a_rdy});
    check_val("ld_ready", {31'd0, ld_ready}, {31'd0, l_rdy});
    check_val("q_count", 32'(q_count), 32'(sz));
    sel = 0; byp = 0; popped = 0; s = '0;
    if (drain) begin
      if (sz > 0) begin s = ld_q.pop_front(); sel = 1; popped = 1; end
    end else if (alu_valid) begin
      s = '{rd: alu_rd, data: alu_data}; sel = 1;
    end else if (sz > 0) begin
      s = ld_q.pop_front(); sel = 1; popped = 1;
    end else if (BYP && ld_valid) begin
      s = '{rd: ld_rd, data: ld_data}; sel = 1; byp = 1;
    end
    alu_acc = alu_valid && a_rdy;
    ld_acc  = ld_valid && l_rdy;
    if (ld_acc && !byp) ld_q.push_back('{rd: ld_rd, data: ld_data});
    if (drain) begin
      drain  = 0;
      starve = 0;
    end else if (popped || sz == 0) begin
      starve = 0;
    end else if (alu_valid) begin
      starve++;
      if (starve == STARVE_MAX) drain = 1;
    end
    exp_wr = sel && (s.rd != 5'd0);
    if (sel) begin
      exp_reg  = s.rd;
      exp_data = s.data;
    end
  endtask

  task automatic drive(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] adat,
                       input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldat);
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid  = lv; ld_rd  = lrd; ld_data  = ldat;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 5'd0, '0, 0, 5'd0, '0);
  endtask

  // Producers keep an unaccepted offer stable until it is taken.
  task automatic rand_cycle(input int p_alu, input int p_ld);
    bit              av, lv;
    logic [4:0]      ard, lrd;
    logic [XLEN-1:0] adat, ldat;
    av = alu_valid; ard = alu_rd; adat = alu_data;
    lv = ld_valid;  lrd = ld_rd;  ldat = ld_data;
    if (!alu_valid || alu_acc) begin
      av = ($urandom_range(99) < p_alu); ard = 5'($urandom_range(7)); adat = $urandom;
    end
    if (!ld_valid || ld_acc) begin
      lv = ($urandom_range(99) < p_ld); lrd = 5'($urandom_range(31)); ldat = $urandom;
    end
    drive(av, ard, adat, lv, lrd, ldat);
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid  = 0; ld_rd  = '0; ld_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    // ALU only
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, '0);
    drive(0, 5'd0, '0, 0, 5'd0, '0);
    check_val("alu_only_reg", {27'd0, write_reg}, 32'd5);
    check_val("alu_only_data", write_data, 32'hDEADBEEF);
    idle(2);

    // Load latency from idle
    drive(0, 5'd0, '0, 1, 5'd7, 32'h12345678);
    idle(3);

    // Starvation: one queued load against a continuous ALU stream
    drive(1, 5'd10, 32'hA0, 1, 5'd9, 32'h900D);
    for (int i = 1; i <= 6; i++) drive(1, 5'(10 + i), 32'hA0 + 32'(i), 0, 5'd0, '0);
    idle(2);

    // Full FIFO with the ALU busy; fifth load is held by its producer
    for (int i = 1; i <= 4; i++) drive(1, 5'(20 + i), 32'hB0 + 32'(i), 1, 5'(i), 32'hC0 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      if (ld_acc) drive(1, 5'(25 + i), 32'hB8 + 32'(i), 0, 5'd0, '0);
      else        drive(1, 5'(25 + i), 32'hB8 + 32'(i), 1, 5'd5, 32'hC5);
    end
    idle(6);

    // x0 suppression on both sources
    drive(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, '0);
    drive(0, 5'd0, '0, 0, 5'd0, '0);
    check_val("x0_alu_wr", {31'd0, RegWr}, 32'd0);
    check_val("x0_alu_data", write_data, 32'hFFFFFFFF);
    drive(1, 5'd3, 32'h33, 1, 5'd0, 32'h5A5A);
    idle(3);

    // Random traffic with varying ALU pressure
    for (int i = 0; i < 300; i++) rand_cycle(50, 50);
    for (int i = 0; i < 300; i++) rand_cycle(90, 70);
    for (int i = 0; i < 200; i++) rand_cycle(20, 40);
    idle(8);

    // Reset mid-stream with two loads queued
    drive(1, 5'd1, 32'h11, 1, 5'd12, 32'hE1);
    drive(1, 5'd2, 32'h22, 1, 5'd13, 32'hE2);
    drive(1, 5'd3, 32'h33, 0, 5'd0, '0);
    check_val("pre_reset_q", 32'(q_count), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_val("rst_RegWr", {31'd0, RegWr}, 32'd0);
    check_val("rst_write_reg", {27'd0, write_reg}, 32'd0);
    check_val("rst_write_data", write_data, 32'd0);
    check_val("rst_q_count", 32'(q_count), 32'd0);
    alu_valid = 0; ld_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    for (int i = 0; i < 100; i++) rand_cycle(60, 60);
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
